// File: rtl/csi2_long_packet_decoder.sv
// CSI-2 long packet decoder: finds the sync word, decodes the packet header and
// streams the payload of RAW long packets with a 1-cycle registered valid strobe.
module csi2_long_packet_decoder #(
    parameter logic [31:0] SYNC_WORD = 32'hB8B8B8B8,
    parameter logic [5:0]  DT_BASE   = 6'h28
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        output_valid_o,
    output logic [31:0] data_o,
    output logic [31:0] packet_length_o,
    output logic [2:0]  packet_type_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [1:0]  r_state;
    logic [16:0] r_count;
    logic        r_valid;
    logic [31:0] r_data;
    logic [15:0] r_length;
    logic [2:0]  r_type;

    logic [5:0]  w_dt;
    logic [15:0] w_wc;
    logic        w_dt_ok;
    logic        w_accept;

    assign w_dt = data_i[5:0];
    assign w_wc = {data_i[23:16], data_i[15:8]};
    // Range compare done one bit wider so DT_BASE+7 cannot wrap for any base.
    assign w_dt_ok  = ({1'b0, w_dt} >= {1'b0, DT_BASE}) &&
                      ({1'b0, w_dt} <= ({1'b0, DT_BASE} + 7'd7));
    assign w_accept = w_dt_ok && (w_wc != 16'd0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= IDLE;
            r_count  <= 17'd0;
            r_valid  <= 1'b0;
            r_data   <= 32'd0;
            r_length <= 16'd0;
            r_type   <= 3'd0;
        end else begin
            r_data  <= data_i;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_valid_i && (data_i == SYNC_WORD)) begin
                        r_state <= HEADER;
                    end
                end
                HEADER: begin
                    if (data_valid_i && w_accept) begin
                        r_length <= w_wc;
                        r_type   <= w_dt[2:0];
                        r_count  <= {1'b0, w_wc};
                        r_state  <= PAYLOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (!data_valid_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_valid <= 1'b1;
                        r_count <= r_count - 17'd4;
                        // Four or fewer bytes left: this word carries the tail.
                        if (r_count <= 17'd4) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign output_valid_o  = r_valid;
    assign data_o          = r_data;
    assign packet_length_o = {16'd0, r_length};
    assign packet_type_o   = r_type;

endmodule

// File: tb/tb_csi2_long_packet_decoder.sv
// Directed bench for csi2_long_packet_decoder: stimulus pushes expected payload
// words into a queue; a negedge monitor pops and compares on every output_valid_o.
module tb_csi2_long_packet_decoder;

    localparam logic [31:0] SYNC = 32'hB8B8B8B8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dv = 1'b0;
    logic [31:0] din = 32'd0;
    logic        out_valid;
    logic [31:0] dout;
    logic [31:0] plen;
    logic [2:0]  ptype;

    always #5 clk = ~clk;

    csi2_long_packet_decoder dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .data_valid_i    (dv),
        .data_i          (din),
        .output_valid_o  (out_valid),
        .data_o          (dout),
        .packet_length_o (plen),
        .packet_type_o   (ptype)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] len;
        logic [2:0]  typ;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   mon_count = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every flagged output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            mon_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_o=%0h len=%0d type=%0d expected no output",
                         dout, plen, ptype);
            end else begin
                mon_e = sb_q.pop_front();
                check("payload{data,len,type}", {29'd0, dout, plen, ptype},
                      {29'd0, mon_e.d, mon_e.len, mon_e.typ});
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        dv  = v;
        din = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0);
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] len, input logic [2:0] typ);
        exp_t e;
        e.d = d; e.len = len; e.typ = typ;
        sb_q.push_back(e);
    endtask

    task automatic drained(input string name);
        check(name, 96'(sb_q.size()), 96'd0);
    endtask

    task automatic check_outs(input string name, input logic [31:0] len, input logic [2:0] typ);
        check({name, "_len"}, 96'(plen), 96'(len));
        check({name, "_type"}, 96'(ptype), 96'(typ));
    endtask

    int base;

    initial begin
        // Reset state
        #2;
        check("reset_valid", 96'(out_valid), 96'd0);
        check("reset_data", 96'(dout), 96'd0);
        check_outs("reset", 32'd0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single RAW10 packet, WC=2400 -> 600 output words, 8 trailing ignored
        idle(4);
        drive(1'b1, 32'd0);
        drive(1'b1, 32'd0);
        drive(1'b1, SYNC);
        drive(1'b1, 32'hAB09602B);
        base = mon_count;
        for (int k = 0; k < 608; k++) begin
            drive(1'b1, 32'(k * 40000));
            if (k < 600) push(32'(k * 40000), 32'd2400, 3'd3);
        end
        idle(3);
        drained("raw10_drained");
        check("raw10_valid_count", 96'(mon_count - base), 96'd600);
        check_outs("raw10", 32'd2400, 3'd3);

        // Rejected headers: frame start, DT=0x1E, DT just below/above range, WC=0
        drive(1'b1, SYNC); drive(1'b1, 32'h77000100); drive(1'b1, 32'h11111111);
        drive(1'b1, SYNC); drive(1'b1, 32'h3309601E); drive(1'b1, 32'h11111111);
        drive(1'b1, SYNC); drive(1'b1, 32'h00000827); drive(1'b1, 32'h11111111);
        drive(1'b1, SYNC); drive(1'b1, 32'h00000830); drive(1'b1, 32'h11111111);
        drive(1'b1, SYNC); drive(1'b1, 32'h0000002B); drive(1'b1, 32'h11111111);
        idle(3);
        drained("reject_drained");
        check_outs("reject", 32'd2400, 3'd3);

        // Odd word count RAW8 WC=10 -> 3 words; then WC=4 (DT 0x2F) and WC=5 (DT 0x28)
        drive(1'b1, SYNC); drive(1'b1, 32'h12000A2A);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'hA0000000 + 32'(k));
            if (k < 3) push(32'hA0000000 + 32'(k), 32'd10, 3'd2);
        end
        idle(1);
        drive(1'b1, SYNC); drive(1'b1, 32'h0000042F);
        drive(1'b1, 32'h5555AAAA); push(32'h5555AAAA, 32'd4, 3'd7);
        drive(1'b1, 32'h66666666);
        drive(1'b1, SYNC); drive(1'b1, 32'h00000528);
        drive(1'b1, 32'h01020304); push(32'h01020304, 32'd5, 3'd0);
        drive(1'b1, 32'h05060708); push(32'h05060708, 32'd5, 3'd0);
        drive(1'b1, 32'h77777777);
        idle(3);
        drained("odd_wc_drained");
        check_outs("odd_wc", 32'd5, 3'd0);

        // Valid drop after 5 payload words of a WC=2400 packet
        drive(1'b1, SYNC); drive(1'b1, 32'hAB09602B);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'hD0000000 + 32'(k));
            push(32'hD0000000 + 32'(k), 32'd2400, 3'd3);
        end
        drive(1'b0, 32'd0);
        for (int k = 0; k < 10; k++) drive(1'b1, 32'hCAFE0000 + 32'(k));
        idle(3);
        drained("drop_drained");
        check_outs("drop", 32'd2400, 3'd3);

        // Reset mid-packet
        drive(1'b1, SYNC); drive(1'b1, 32'hAB09602B);
        drive(1'b1, 32'hE0000000); push(32'hE0000000, 32'd2400, 3'd3);
        drive(1'b1, 32'hE0000001); push(32'hE0000001, 32'd2400, 3'd3);
        drive(1'b1, 32'hE0000002);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        dv = 1'b0;
        #1;
        check("midreset_valid", 96'(out_valid), 96'd0);
        check("midreset_data", 96'(dout), 96'd0);
        check_outs("midreset", 32'd0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drained("midreset_drained");
        drive(1'b1, 32'hE0000003);
        drive(1'b1, SYNC); drive(1'b1, 32'h0000082B);
        drive(1'b1, 32'hF0000000); push(32'hF0000000, 32'd8, 3'd3);
        drive(1'b1, 32'hF0000001); push(32'hF0000001, 32'd8, 3'd3);
        idle(3);
        drained("post_reset_drained");

        // Back-to-back RAW12 packets, second with VC=1 and a sync word as data
        drive(1'b1, SYNC); drive(1'b1, 32'hEE00102C);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h12120000 + 32'(k));
            push(32'h12120000 + 32'(k), 32'd16, 3'd4);
        end
        drive(1'b0, 32'd0);
        drive(1'b1, SYNC); drive(1'b1, 32'hEE00106C);
        drive(1'b1, SYNC); push(SYNC, 32'd16, 3'd4);
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 32'h34340000 + 32'(k));
            push(32'h34340000 + 32'(k), 32'd16, 3'd4);
        end
        idle(3);
        drained("b2b_drained");
        check_outs("b2b", 32'd16, 3'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
